// File: rtl/mem_pkg.sv
// Shared encodings, FSM states and lane helpers for the load/store unit.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ADDR,
    S_WAIT_DATA,
    S_CANCEL,
    S_DONE
  } state_t;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return ((size == SZ_HALF) && off[0]) ||
           ((size == SZ_WORD) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] lane_strb(
    input logic       wr,
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] s;
    s = 4'b0000;
    if (wr) begin
      unique case (1'b1)
        size == SZ_BYTE: s = 4'b0001 << off;
        size == SZ_HALF: s = off[1] ? 4'b1100 : 4'b0011;
        default:         s = 4'b1111;
      endcase
    end
    return s;
  endfunction

  function automatic logic [31:0] lane_data(
    input logic [1:0]  size,
    input logic [31:0] d
  );
    logic [31:0] r;
    r = d;
    unique case (1'b1)
      size == SZ_BYTE: r = {4{d[7:0]}};
      size == SZ_HALF: r = {2{d[15:0]}};
      default:         r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data extraction: lane shift followed by zero/sign extension.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] res
);

  logic [31:0] sh;

  assign sh = raw >> {off, 3'b000};

  always_comb begin
    res = sh;
    unique case (1'b1)
      size == SZ_BYTE: res = {{24{sgn & sh[7]}}, sh[7:0]};
      size == SZ_HALF: res = {{16{sgn & sh[15]}}, sh[15:0]};
      default:         res = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit on a req/addr_ok/data_ok bus.
// MEM_MISALIGN_EXC_EN: misaligned accesses raise adel/ades instead of aligning down.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] badvaddr,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  state_t state, nxt;

  logic              idle, live, mis, fault, issue;
  logic              flushed;
  logic [ADDR_W-1:0] issue_addr, addr_q;
  logic [DATA_W-1:0] wdata_q, ld_data;
  logic [3:0]        strb_q;
  logic [1:0]        off_q, size_q;
  logic              sgn_q, wr_q;

  assign idle = (state == S_IDLE);
  assign live = req_valid & ~flush;
  assign mis  = misaligned(req_size, addr[1:0]);

`ifdef MEM_MISALIGN_EXC_EN
  logic [ADDR_W-1:0] bad_q;

  assign fault      = mis;
  assign issue_addr = addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bad_q <= '0;
    else if (adel | ades)
      bad_q <= addr;
  end

  assign badvaddr = (adel | ades) ? addr : bad_q;
`else
  logic [1:0] amask;

  assign fault      = 1'b0;
  assign amask      = (req_size == SZ_WORD) ? 2'b00 :
                      (req_size == SZ_HALF) ? 2'b10 : 2'b11;
  assign issue_addr = {addr[ADDR_W-1:2], addr[1:0] & amask};
  assign badvaddr   = '0;
`endif

  assign adel  = rst & idle & live & fault & ~req_wr;
  assign ades  = rst & idle & live & fault & req_wr;
  assign issue = rst & idle & live & ~fault;

  // A request already on the bus stays up until accepted, flush or not.
  assign data_req = issue | (rst & (state == S_WAIT_ADDR));
  assign stall    = live & (state != S_DONE) & ~(idle & fault);

  always_comb begin
    data_addr  = '0;
    data_wdata = '0;
    data_size  = '0;
    data_wstrb = '0;
    data_wr    = 1'b0;
    if (issue) begin
      data_addr  = issue_addr;
      data_wdata = lane_data(req_size, wdata);
      data_size  = req_size;
      data_wstrb = lane_strb(req_wr, req_size, issue_addr[1:0]);
      data_wr    = req_wr;
    end else if (data_req) begin
      data_addr  = addr_q;
      data_wdata = wdata_q;
      data_size  = size_q;
      data_wstrb = strb_q;
      data_wr    = wr_q;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (issue)
          nxt = data_addr_ok ? S_WAIT_DATA : S_WAIT_ADDR;
      S_WAIT_ADDR:
        if (data_addr_ok)
          nxt = (flushed | flush) ? S_CANCEL : S_WAIT_DATA;
      S_WAIT_DATA:
        if (data_data_ok)
          nxt = flush ? S_IDLE : S_DONE;
        else if (flush)
          nxt = S_CANCEL;
      S_CANCEL:
        if (data_data_ok)
          nxt = S_IDLE;
      S_DONE:
        nxt = S_IDLE;
      default:
        nxt = S_IDLE;
    endcase
  end

  mem_load_align u_align (
    .raw  (data_rdata),
    .off  (off_q),
    .size (size_q),
    .sgn  (sgn_q),
    .res  (ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      flushed     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      off_q       <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      wr_q        <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      state <= nxt;
      if (issue) begin
        flushed <= 1'b0;
        addr_q  <= issue_addr;
        wdata_q <= lane_data(req_size, wdata);
        strb_q  <= lane_strb(req_wr, req_size, issue_addr[1:0]);
        off_q   <= issue_addr[1:0];
        size_q  <= req_size;
        sgn_q   <= req_signed;
        wr_q    <= req_wr;
      end else if ((state == S_WAIT_ADDR) && flush) begin
        flushed <= 1'b1;
      end
      if ((state == S_WAIT_DATA) && data_data_ok && !flush && !wr_q) begin
        rdata       <= ld_data;
        rdata_valid <= 1'b1;
      end else begin
        rdata       <= '0;
        rdata_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_wr, req_signed, flush;
  logic [1:0]  req_size;
  logic [31:0] addr, wdata;
  logic        stall, rdata_valid, adel, ades;
  logic [31:0] rdata, badvaddr;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_wr       (req_wr),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .addr         (addr),
    .wdata        (wdata),
    .flush        (flush),
    .stall        (stall),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .adel         (adel),
    .ades         (ades),
    .badvaddr     (badvaddr),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wstrb   (data_wstrb),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req_valid    = 1'b0;
    req_wr       = 1'b0;
    req_size     = 2'd0;
    req_signed   = 1'b0;
    addr         = '0;
    wdata        = '0;
    flush        = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
  endtask

  initial begin
    idle_in();
    #12;
    check("rst_req", 32'(data_req), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_rvalid", 32'(rdata_valid), 32'd0);
    check("rst_adel", 32'(adel), 32'd0);
    check("rst_bad", badvaddr, 32'h0);
    cyc();
    rst = 1'b1;

    // lb signed, best case
    cyc();
    req_valid = 1'b1; req_size = 2'd0; req_signed = 1'b1;
    addr = 32'h0000_1003; data_addr_ok = 1'b1;
    #1;
    check("lb_req", 32'(data_req), 32'd1);
    check("lb_addr", data_addr, 32'h0000_1003);
    check("lb_strb", 32'(data_wstrb), 32'h0);
    check("lb_stall0", 32'(stall), 32'd1);
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    data_rdata = 32'h80FF_1234;
    #1;
    check("lb_stall1", 32'(stall), 32'd1);
    check("lb_req1", 32'(data_req), 32'd0);
    cyc();
    data_data_ok = 1'b0;
    #1;
    check("lb_stall2", 32'(stall), 32'd0);
    check("lb_rvalid", 32'(rdata_valid), 32'd1);
    check("lb_rdata", rdata, 32'hFFFF_FF80);
    cyc();
    idle_in();
    #1;
    check("lb_clr_v", 32'(rdata_valid), 32'd0);
    check("lb_clr_d", rdata, 32'h0);

    // sh with one wait cycle on data_ok
    cyc();
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd1;
    addr = 32'h0000_2002; wdata = 32'h0000_ABCD; data_addr_ok = 1'b1;
    #1;
    check("sh_wdata", data_wdata, 32'hABCD_ABCD);
    check("sh_strb", 32'(data_wstrb), 32'hC);
    check("sh_wr", 32'(data_wr), 32'd1);
    check("sh_stall0", 32'(stall), 32'd1);
    cyc();
    data_addr_ok = 1'b0;
    #1;
    check("sh_stall1", 32'(stall), 32'd1);
    cyc();
    data_data_ok = 1'b1;
    #1;
    check("sh_stall2", 32'(stall), 32'd1);
    cyc();
    data_data_ok = 1'b0;
    #1;
    check("sh_stall3", 32'(stall), 32'd0);
    check("sh_rvalid", 32'(rdata_valid), 32'd0);
    cyc();
    idle_in();

    // lhu with addr_ok delayed 3 cycles; address input changes meanwhile
    cyc();
    req_valid = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    addr = 32'h0000_4006;
    #1;
    check("dly_req0", 32'(data_req), 32'd1);
    check("dly_addr0", data_addr, 32'h0000_4006);
    for (int i = 0; i < 3; i++) begin
      cyc();
      addr = 32'hDEAD_0000;
      if (i == 2) data_addr_ok = 1'b1;
      #1;
      check("dly_req", 32'(data_req), 32'd1);
      check("dly_addr", data_addr, 32'h0000_4006);
      check("dly_size", 32'(data_size), 32'd1);
      check("dly_stall", 32'(stall), 32'd1);
    end
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    data_rdata = 32'h9876_5432;
    #1;
    check("dly_req_lo", 32'(data_req), 32'd0);
    cyc();
    data_data_ok = 1'b0;
    #1;
    check("dly_rdata", rdata, 32'h0000_9876);
    check("dly_rvalid", 32'(rdata_valid), 32'd1);
    cyc();
    idle_in();

    // flush in WAIT_DATA, next lw waits for the drain
    cyc();
    req_valid = 1'b1; req_size = 2'd2; addr = 32'h0000_5000;
    data_addr_ok = 1'b1;
    #1;
    check("fl_req0", 32'(data_req), 32'd1);
    cyc();
    data_addr_ok = 1'b0; flush = 1'b1;
    #1;
    check("fl_stall", 32'(stall), 32'd0);
    cyc();
    flush = 1'b0; addr = 32'h0000_6004;
    #1;
    check("fl_cstall", 32'(stall), 32'd1);
    check("fl_creq", 32'(data_req), 32'd0);
    cyc();
    data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
    #1;
    check("fl_dstall", 32'(stall), 32'd1);
    check("fl_dreq", 32'(data_req), 32'd0);
    cyc();
    data_data_ok = 1'b0; data_addr_ok = 1'b1;
    #1;
    check("fl_nreq", 32'(data_req), 32'd1);
    check("fl_naddr", data_addr, 32'h0000_6004);
    check("fl_noold", 32'(rdata_valid), 32'd0);
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    data_rdata = 32'h2222_2222;
    cyc();
    data_data_ok = 1'b0;
    #1;
    check("fl_rdata", rdata, 32'h2222_2222);
    check("fl_rvalid", 32'(rdata_valid), 32'd1);
    check("fl_stall2", 32'(stall), 32'd0);
    cyc();
    idle_in();

    // misaligned lw at 0x3001
`ifdef MEM_MISALIGN_EXC_EN
    cyc();
    req_valid = 1'b1; req_size = 2'd2; addr = 32'h0000_3001;
    #1;
    check("mis_adel", 32'(adel), 32'd1);
    check("mis_ades", 32'(ades), 32'd0);
    check("mis_bad", badvaddr, 32'h0000_3001);
    check("mis_req", 32'(data_req), 32'd0);
    check("mis_stall", 32'(stall), 32'd0);
    cyc();
    idle_in();
    #1;
    check("mis_adel0", 32'(adel), 32'd0);
    check("mis_badh", badvaddr, 32'h0000_3001);
`else
    cyc();
    req_valid = 1'b1; req_size = 2'd2; addr = 32'h0000_3001;
    data_addr_ok = 1'b1;
    #1;
    check("mis_req", 32'(data_req), 32'd1);
    check("mis_addr", data_addr, 32'h0000_3000);
    check("mis_adel", 32'(adel), 32'd0);
    check("mis_stall", 32'(stall), 32'd1);
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    data_rdata = 32'hCAFE_F00D;
    cyc();
    data_data_ok = 1'b0;
    #1;
    check("mis_rdata", rdata, 32'hCAFE_F00D);
    check("mis_rvalid", 32'(rdata_valid), 32'd1);
    cyc();
    idle_in();
`endif

    // reset while waiting for addr_ok
    cyc();
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd2;
    addr = 32'h0000_7000; wdata = 32'h55AA_55AA;
    #1;
    check("rw_req0", 32'(data_req), 32'd1);
    cyc();
    #1;
    check("rw_req1", 32'(data_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rw_req", 32'(data_req), 32'd0);
    check("rw_addr", data_addr, 32'h0);
    check("rw_strb", 32'(data_wstrb), 32'h0);
    check("rw_rvalid", 32'(rdata_valid), 32'd0);
    check("rw_rdata", rdata, 32'h0);
    check("rw_ades", 32'(ades), 32'd0);
    check("rw_bad", badvaddr, 32'h0);
    cyc();
    idle_in();
    cyc();
    rst = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h3333_3333;
    cyc();
    data_data_ok = 1'b0;
    #1;
    check("rw_late_v", 32'(rdata_valid), 32'd0);
    check("rw_late_r", 32'(data_req), 32'd0);

    // lbu after reset recovery
    cyc();
    req_valid = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    addr = 32'h0000_8001; data_addr_ok = 1'b1;
    #1;
    check("lbu_req", 32'(data_req), 32'd1);
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    data_rdata = 32'h0000_AB00;
    cyc();
    data_data_ok = 1'b0;
    #1;
    check("lbu_rdata", rdata, 32'h0000_00AB);
    check("lbu_rvalid", 32'(rdata_valid), 32'd1);
    cyc();
    idle_in();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
